// File: rtl/vga_pkg.sv
// Shared types, code points and step functions for the face streamer's
// configuration sequencer.
package vga_pkg;

    typedef enum logic [1:0] {
        FACE_WOLF   = 2'd0,
        FACE_P2     = 2'd1,
        FACE_COLOUR = 2'd2
    } face_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } seq_state_t;

    localparam logic [3:0] FILT_NONE    = 4'b0000;
    localparam logic [3:0] FILT_INVERT  = 4'b0001;
    localparam logic [3:0] FILT_LIGHTEN = 4'b0010;
    localparam logic [3:0] FILT_DARKEN  = 4'b0100;
    localparam logic [3:0] FILT_RED     = 4'b0011;
    localparam logic [3:0] FILT_GREY    = 4'b1000;
    localparam logic [3:0] FILT_BLUR    = 4'b1111;

    localparam int VGA_W        = 640;
    localparam int VGA_H        = 480;
    localparam int SRC_W        = 160;
    localparam int SRC_H        = 120;
    localparam int FRAME_PIXELS = VGA_W * VGA_H;

    function automatic face_t next_face(input face_t f);
        case (f)
            FACE_WOLF: next_face = FACE_P2;
            FACE_P2:   next_face = FACE_COLOUR;
            default:   next_face = FACE_WOLF;
        endcase
    endfunction

    // Illegal codes fall back to FILT_NONE so a stray value self-heals.
    function automatic logic [3:0] next_filter(input logic [3:0] f);
        case (f)
            FILT_NONE:    next_filter = FILT_INVERT;
            FILT_INVERT:  next_filter = FILT_LIGHTEN;
            FILT_LIGHTEN: next_filter = FILT_DARKEN;
            FILT_DARKEN:  next_filter = FILT_RED;
            FILT_RED:     next_filter = FILT_GREY;
            FILT_GREY:    next_filter = FILT_BLUR;
            default:      next_filter = FILT_NONE;
        endcase
    endfunction

    function automatic logic filter_legal(input logic [3:0] f);
        case (f)
            FILT_NONE, FILT_INVERT, FILT_LIGHTEN, FILT_DARKEN,
            FILT_RED, FILT_GREY, FILT_BLUR: filter_legal = 1'b1;
            default:                        filter_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vga_frame_timer.sv
// Auto-slideshow frame counter: emits a tick on the frame_end that completes
// AUTO_FRAMES idle frames.
module vga_frame_timer
    import vga_pkg::*;
#(
    parameter int AUTO_FRAMES = 180
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_end,
    input  logic auto_en,
    input  logic count_en,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(AUTO_FRAMES - 1);

    logic [15:0] cnt_reg;
    logic        at_last;

    assign at_last = (cnt_reg == LAST);
    assign tick    = auto_en & count_en & frame_end & at_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (!auto_en || clear) begin
            cnt_reg <= '0;
        end else if (frame_end && count_en) begin
            cnt_reg <= at_last ? 16'd0 : cnt_reg + 16'd1;
        end
    end

endmodule

// File: rtl/vga_mode_sequencer.sv
// Arbitrates command, key and slideshow requests for face/filter selection
// and commits the staged choice only on a frame boundary.
module vga_mode_sequencer
    import vga_pkg::*;
#(
    parameter int AUTO_FRAMES = 180,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pix_fire,
    input  logic                   pix_eop,
    input  logic                   key_face,
    input  logic                   key_filter,
    input  logic                   auto_en,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_face,
    input  logic [3:0]             cmd_filter,
    output logic [1:0]             face_select,
    output logic [3:0]             filter_select,
    output logic                   cfg_pending,
    output logic                   cmd_error,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    seq_state_t             state_reg,         state_next;
    face_t                  face_reg,          face_next;
    logic [3:0]             filter_reg,        filter_next;
    face_t                  staged_face_reg,   staged_face_next;
    logic [3:0]             staged_filter_reg, staged_filter_next;
    logic                   cmd_error_reg,     cmd_error_next;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;

    logic  frame_end;
    logic  auto_tick;
    logic  stage_clear;
    logic  cmd_legal;
    face_t armed_face;
    logic [3:0] armed_filter;

    assign frame_end = pix_fire & pix_eop;
    assign cmd_legal = (cmd_face != 2'd3) && filter_legal(cmd_filter);

    vga_frame_timer #(
        .AUTO_FRAMES(AUTO_FRAMES)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_end (frame_end),
        .auto_en   (auto_en),
        .count_en  (state_reg == ST_IDLE),
        .clear     (stage_clear),
        .tick      (auto_tick)
    );

    // Key pulses landing while armed stack onto the staged fields.
    assign armed_face   = key_face   ? next_face(staged_face_reg)     : staged_face_reg;
    assign armed_filter = key_filter ? next_filter(staged_filter_reg) : staged_filter_reg;

    always_comb begin
        state_next         = state_reg;
        face_next          = face_reg;
        filter_next        = filter_reg;
        staged_face_next   = staged_face_reg;
        staged_filter_next = staged_filter_reg;
        cmd_error_next     = 1'b0;
        stage_clear        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A command owns the cycle even when rejected.
                if (cmd_valid) begin
                    if (cmd_legal) begin
                        staged_face_next   = face_t'(cmd_face);
                        staged_filter_next = cmd_filter;
                        stage_clear        = 1'b1;
                        state_next         = ST_ARMED;
                    end else begin
                        cmd_error_next = 1'b1;
                    end
                end else if (key_face || key_filter) begin
                    staged_face_next   = key_face   ? next_face(face_reg)     : face_reg;
                    staged_filter_next = key_filter ? next_filter(filter_reg) : filter_reg;
                    stage_clear        = 1'b1;
                    state_next         = ST_ARMED;
                end else if (auto_tick) begin
                    staged_face_next   = next_face(face_reg);
                    staged_filter_next = filter_reg;
                    state_next         = ST_ARMED;
                end
            end
            default: begin
                staged_face_next   = armed_face;
                staged_filter_next = armed_filter;
                if (frame_end) begin
                    face_next   = armed_face;
                    filter_next = armed_filter;
                    state_next  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            face_reg          <= FACE_WOLF;
            filter_reg        <= FILT_NONE;
            staged_face_reg   <= FACE_WOLF;
            staged_filter_reg <= FILT_NONE;
            cmd_error_reg     <= 1'b0;
            frame_cnt_reg     <= '0;
        end else begin
            state_reg         <= state_next;
            face_reg          <= face_next;
            filter_reg        <= filter_next;
            staged_face_reg   <= staged_face_next;
            staged_filter_reg <= staged_filter_next;
            cmd_error_reg     <= cmd_error_next;
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign cmd_ready     = (state_reg == ST_IDLE);
    assign cfg_pending   = (state_reg == ST_ARMED);
    assign face_select   = face_reg;
    assign filter_select = filter_reg;
    assign cmd_error     = cmd_error_reg;
    assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer: cycle table plus slideshow and
// frame-counter wrap sequences, using short frames.
module tb_vga_mode_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_fire = 1'b0, pix_eop = 1'b0;
    logic        key_face = 1'b0, key_filter = 1'b0, auto_en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_face = 2'd0;
    logic [3:0]  cmd_filter = 4'd0;
    logic [1:0]  face_select;
    logic [3:0]  filter_select;
    logic        cfg_pending, cmd_error;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_mode_sequencer #(.AUTO_FRAMES(2), .FRAME_CNT_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pix_fire      (pix_fire),
        .pix_eop       (pix_eop),
        .key_face      (key_face),
        .key_filter    (key_filter),
        .auto_en       (auto_en),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_face      (cmd_face),
        .cmd_filter    (cmd_filter),
        .face_select   (face_select),
        .filter_select (filter_select),
        .cfg_pending   (cfg_pending),
        .cmd_error     (cmd_error),
        .frame_cnt     (frame_cnt)
    );

    typedef struct {
        logic        rst_n, fire, eop, kf, kfl, cv;
        logic [1:0]  cf;
        logic [3:0]  cfl;
        logic [1:0]  ef;
        logic [3:0]  efl;
        logic        ep, er, ee;
        logic [15:0] efc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic f, input logic e, input logic kf,
                         input logic kfl, input logic cv, input logic [1:0] cf, input logic [3:0] cfl);
        reset_n = rn; pix_fire = f; pix_eop = e; key_face = kf; key_filter = kfl;
        cmd_valid = cv; cmd_face = cf; cmd_filter = cfl;
    endtask

    initial begin
        // rst fire eop kf kfl cv cf cfl | face filt pend ready err fcnt
        vq.push_back('{0,0,0,0,0,0,2'd0,4'h0, 2'd0,4'h0,0,1,0,16'd0});
        vq.push_back('{1,1,0,0,0,0,2'd0,4'h0, 2'd0,4'h0,0,1,0,16'd0});
        vq.push_back('{1,1,0,0,1,0,2'd0,4'h0, 2'd0,4'h0,1,0,0,16'd0});
        vq.push_back('{1,1,0,0,0,0,2'd0,4'h0, 2'd0,4'h0,1,0,0,16'd0});
        vq.push_back('{1,1,1,0,0,0,2'd0,4'h0, 2'd0,4'h1,0,1,0,16'd1});
        vq.push_back('{1,0,0,1,0,0,2'd0,4'h0, 2'd0,4'h1,1,0,0,16'd1});
        vq.push_back('{1,0,0,1,0,0,2'd0,4'h0, 2'd0,4'h1,1,0,0,16'd1});
        vq.push_back('{1,0,0,1,0,0,2'd0,4'h0, 2'd0,4'h1,1,0,0,16'd1});
        vq.push_back('{1,1,1,0,0,0,2'd0,4'h0, 2'd0,4'h1,0,1,0,16'd2});
        vq.push_back('{1,0,0,1,0,0,2'd0,4'h0, 2'd0,4'h1,1,0,0,16'd2});
        vq.push_back('{1,1,1,0,0,0,2'd0,4'h0, 2'd1,4'h1,0,1,0,16'd3});
        vq.push_back('{1,0,0,1,0,1,2'd2,4'hF, 2'd1,4'h1,1,0,0,16'd3});
        vq.push_back('{1,0,0,0,0,1,2'd0,4'h2, 2'd1,4'h1,1,0,0,16'd3});
        vq.push_back('{1,1,1,0,0,1,2'd0,4'h2, 2'd2,4'hF,0,1,0,16'd4});
        vq.push_back('{1,0,0,0,0,1,2'd0,4'h2, 2'd2,4'hF,1,0,0,16'd4});
        vq.push_back('{1,1,1,0,0,0,2'd0,4'h0, 2'd0,4'h2,0,1,0,16'd5});
        vq.push_back('{1,1,1,0,1,0,2'd0,4'h0, 2'd0,4'h2,1,0,0,16'd6});
        vq.push_back('{1,1,1,0,0,0,2'd0,4'h0, 2'd0,4'h4,0,1,0,16'd7});
        vq.push_back('{1,0,0,0,0,1,2'd3,4'h5, 2'd0,4'h4,0,1,1,16'd7});
        vq.push_back('{1,0,0,0,0,0,2'd0,4'h0, 2'd0,4'h4,0,1,0,16'd7});
        vq.push_back('{1,0,0,0,0,1,2'd1,4'h5, 2'd0,4'h4,0,1,1,16'd7});
        vq.push_back('{1,0,0,0,0,1,2'd3,4'h0, 2'd0,4'h4,0,1,1,16'd7});
        vq.push_back('{1,0,0,0,0,0,2'd0,4'h0, 2'd0,4'h4,0,1,0,16'd7});
        vq.push_back('{1,0,0,0,0,1,2'd1,4'h8, 2'd0,4'h4,1,0,0,16'd7});
        vq.push_back('{1,1,1,0,1,0,2'd0,4'h0, 2'd1,4'hF,0,1,0,16'd8});
        vq.push_back('{1,0,0,0,0,1,2'd1,4'h2, 2'd1,4'hF,1,0,0,16'd8});
        vq.push_back('{0,1,1,0,0,0,2'd0,4'h0, 2'd0,4'h0,0,1,0,16'd0});
        vq.push_back('{1,1,1,0,0,0,2'd0,4'h0, 2'd0,4'h0,0,1,0,16'd1});

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst_n, vq[i].fire, vq[i].eop, vq[i].kf, vq[i].kfl,
                  vq[i].cv, vq[i].cf, vq[i].cfl);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {7'd0, face_select, filter_select, cfg_pending, cmd_ready, cmd_error, frame_cnt},
                  {7'd0, vq[i].ef, vq[i].efl, vq[i].ep, vq[i].er, vq[i].ee, vq[i].efc});
        end

        // Slideshow with AUTO_FRAMES=2: two counted frames, then one commit frame.
        begin
            logic [1:0] exp_face [13] = '{0,0,1,1,1,2,2,2,0,0,0,0,1};
            logic       exp_pend [13] = '{0,1,0,0,1,0,0,1,0,0,0,1,0};
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 0, 2'd0, 4'h0);
            auto_en = 1'b1;
            for (int i = 0; i < 13; i++) begin
                if (i == 10) begin
                    @(negedge clk);
                    auto_en = 1'b0;
                    @(negedge clk);
                    auto_en = 1'b1;
                end
                @(negedge clk);
                pix_fire = 1'b1; pix_eop = 1'b1;
                @(posedge clk); #1;
                check($sformatf("auto%0d", i), {29'd0, face_select, cfg_pending},
                      {29'd0, exp_face[i], exp_pend[i]});
                @(negedge clk);
                pix_fire = 1'b0; pix_eop = 1'b0;
            end
            auto_en = 1'b0;
        end

        // Frame counter wrap after a long run of back-to-back frame ends.
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; pix_fire = 1'b1; pix_eop = 1'b1;
        repeat (65535) @(posedge clk);
        #1 check("fcnt_max", {16'd0, frame_cnt}, 32'h0000_FFFF);
        @(posedge clk); #1;
        check("fcnt_wrap", {16'd0, frame_cnt}, 32'h0);
        check("wrap_face", {28'd0, face_select, 2'd0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
